// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-byte fetch engine.
package fetch_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VEC = 16'hFFFC;

  typedef enum logic [1:0] {
    IDLE,
    VEC_LO,
    VEC_HI,
    RUN
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Pointer width that stays legal for a single-entry buffer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular storage of fetched bytes with their addresses.
// Synchronous flush has priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; flush discards everything including a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-byte fetch engine: reset-vector load, sequential byte reads, prefetch buffer.
// Define FETCH_PREFETCH_EN to let fetch run DEPTH bytes ahead; otherwise single-entry buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic              ph1,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic [ADDR_W-1:0] byte_pc,
  input  logic              byte_ready
);

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned EFF_DEPTH = DEPTH;
`else
  // DEPTH has no effect without prefetch; the buffer holds one byte.
  localparam int unsigned EFF_DEPTH = (DEPTH > 0) ? 1 : 1;
`endif

  localparam logic [ADDR_W-1:0] VEC_HI_ADDR = ADDR_W'(RESET_VEC + 16'd1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              flush;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, PC update and bus request; redirect in RUN suppresses the request and drops any ack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_req  = 1'b0;
    mem_addr = pc_q;
    push     = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: begin
        mem_addr = RESET_VEC;
        state_d  = VEC_LO;
      end
      VEC_LO: begin
        mem_addr = RESET_VEC;
        mem_req  = 1'b1;
        if (mem_ack) begin
          pc_d[7:0] = mem_data;
          state_d   = VEC_HI;
        end
      end
      VEC_HI: begin
        mem_addr = VEC_HI_ADDR;
        mem_req  = 1'b1;
        if (mem_ack) begin
          pc_d[15:8] = mem_data;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end else begin
          mem_req = ~fifo_full;
          if (mem_req && mem_ack) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_entry = '{data: mem_data, pc: pc_q};
  assign pop      = byte_valid & byte_ready;

  fetch_fifo #(
    .DEPTH(EFF_DEPTH)
  ) u_fifo (
    .clk  (ph1),
    .rst  (reset),
    .flush(flush),
    .push (push),
    .wdata(wr_entry),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign byte_valid = ~fifo_empty;
  assign byte_data  = head.data;
  assign byte_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of the fetch stream.
module tb_fetch_unit;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [15:0] byte_pc;
  logic        byte_ready = 1'b0;

  fetch_unit #(.DEPTH(4), .RESET_VEC(16'hFFFC)) dut (
    .ph1        (ph1),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_pc    (byte_pc),
    .byte_ready (byte_ready)
  );

  always #5 ph1 = ~ph1;

`ifdef FETCH_PREFETCH_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [65536];

  // Model: phase 0 idle, 1/2 reading vector bytes, 3 streaming.
  int          m_phase;
  logic [15:0] m_pc;
  logic [23:0] m_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 16'h0000;
    m_q.delete();
  endtask

  // One clock: drive inputs after a falling edge, check outputs, advance the model.
  task automatic cycle(input bit ack, input bit rdy, input bit redir, input logic [15:0] rpc);
    bit          exp_req;
    logic [15:0] exp_addr;
    bit          pop;
    mem_ack     = ack;
    byte_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    mem_data = mem[mem_addr];
    #1;
    case (m_phase)
      0:       begin exp_req = 0; exp_addr = 16'hFFFC; end
      1:       begin exp_req = 1; exp_addr = 16'hFFFC; end
      2:       begin exp_req = 1; exp_addr = 16'hFFFD; end
      default: begin exp_req = !redir && (m_q.size() < CAP); exp_addr = m_pc; end
    endcase
    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check("byte_valid", 32'(byte_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("byte_head", {8'h00, byte_data, byte_pc}, {8'h00, m_q[0]});
    pop = (m_q.size() != 0) && rdy;
    case (m_phase)
      0: m_phase = 1;
      1: if (ack) begin m_pc[7:0] = mem[16'hFFFC]; m_phase = 2; end
      2: if (ack) begin m_pc[15:8] = mem[16'hFFFD]; m_phase = 3; end
      default: begin
        if (redir) begin
          m_q.delete();
          m_pc = rpc;
        end else begin
          if (pop) void'(m_q.pop_front());
          if (exp_req && ack) begin
            m_q.push_back({mem[m_pc], m_pc});
            m_pc = m_pc + 16'd1;
          end
        end
      end
    endcase
    @(posedge ph1);
    @(negedge ph1);
  endtask

  task automatic release_reset();
    @(negedge ph1);
    reset = 1'b0;
    model_reset();
  endtask

  int guard;
  int target;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    model_reset();

    // Reset state while reset is held.
    @(negedge ph1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'hFFFC);
    check("rst_valid", 32'(byte_valid), 32'd0);
    release_reset();

    // Reset vector then streaming with ack tied high.
    for (int i = 0; i < 16; i++) cycle(1, 1, 0, 16'h0);

    // Backpressure, a single pop, then more backpressure.
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 16'h0);
    cycle(1, 1, 0, 16'h0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 16'h0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 16'h0);

    // Restart and redirect on a cycle whose address is 8002 with ack high.
    reset = 1'b1;
    release_reset();
    guard = 0;
    while (!(m_phase == 3 && m_pc == 16'h8002) && guard < 50) begin
      cycle(1, 1, 0, 16'h0);
      guard++;
    end
    check("reach_8002", 32'(m_pc), 32'h8002);
    cycle(1, 1, 1, 16'hC000);
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 16'h0);

    // Wrap through FFFF.
    cycle(1, 1, 1, 16'hFFFE);
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 16'h0);

    // Async reset mid-stream with buffer partly filled.
    target = (CAP < 3) ? CAP : 3;
    guard = 0;
    while (m_q.size() < target && guard < 50) begin
      cycle(1, 0, 0, 16'h0);
      guard++;
    end
    check("fill_level", 32'(m_q.size()), 32'(target));
    #2;
    reset = 1'b1;
    #1;
    check("areset_req", 32'(mem_req), 32'd0);
    check("areset_valid", 32'(byte_valid), 32'd0);
    check("areset_addr", 32'(mem_addr), 32'hFFFC);
    release_reset();
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 16'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 5)) : 16'($urandom);
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 4, rpc);
      if ($urandom_range(0, 999) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        check("rand_rst_req", 32'(mem_req), 32'd0);
        release_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-byte fetch engine that produces the opcode/operand byte stream consumed by the control FSM's opcode latch. After reset it reads the 6502 reset vector and loads the program counter. It then issues sequential single-byte memory reads over a request/acknowledge bus. Returned bytes are buffered in a small prefetch FIFO and presented to the controller with a valid/ready handshake, and a redirect input flushes the stream for jumps and branches.

## Interface
- DEPTH, 4, prefetch FIFO entries; power of two, 1–8
- RESET_VEC, 16'hFFFC, address of reset-vector low byte; high byte at RESET_VEC+1
- ph1  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_addr  out  16  read address; stable while mem_req high unless redirect
- mem_req  out  1  read request
- mem_ack  in  1  memory accepted request; mem_data valid this cycle
- mem_data  in  8  read data
- redirect  in  1  flush FIFO, load PC from redirect_pc
- redirect_pc  in  16  new fetch address
- byte_valid  out  1  byte_data/byte_pc hold a fetched byte
- byte_data  out  8  head-of-FIFO byte
- byte_pc  out  16  address the head byte came from
- byte_ready  in  1  controller consumes head byte when byte_valid high

## Operation
- States: IDLE → VEC_LO → VEC_HI → RUN.
  - IDLE is the reset state and always advances after one cycle.
  - VEC_LO: mem_addr=RESET_VEC, mem_req=1. On ack, latch pc[7:0]=mem_data and go to VEC_HI.
  - VEC_HI: mem_addr=RESET_VEC+1, mem_req=1. On ack, latch pc[15:8]=mem_data and go to RUN.
  - RUN: mem_addr=pc. mem_req=1 when count<DEPTH and redirect=0. On ack, push {mem_data, pc} and set pc=pc+1.
- One outstanding request at a time. A transfer completes in the cycle where mem_req&mem_ack are both high.
- PC arithmetic is 16-bit modulo: FFFF+1=0000. Vector address increment also wraps.
- Output: byte_valid = count!=0. A pop occurs on byte_valid&byte_ready.
- Push and pop in the same cycle leave count unchanged.
- Full (count=DEPTH): mem_req=0. A pop frees a slot, and mem_req returns in the next cycle.
- Empty: byte_valid=0 and byte_data/byte_pc are don't-care. Pop with byte_valid=0 is ignored.
- Redirect (RUN only; ignored in IDLE/VEC_*): the next edge sets count=0 and pc=redirect_pc.
  - Any same-cycle ack is discarded: no push, no pc increment.
  - A same-cycle pop is irrelevant, because the flush wins.
  - While redirect=1, mem_req=0. Memory must tolerate an abandoned request, meaning req dropping without ack.
- Reset mid-operation: all state returns to IDLE immediately. Any in-flight request is abandoned.

## Timing
- Reset values: state=IDLE, pc=0000, count=0, mem_req=0, mem_addr=RESET_VEC, byte_valid=0.
- mem_req and mem_addr are combinational from registered state and count. mem_ack and mem_data are sampled on the ph1 rising edge.
- Ack at edge N → byte_valid=1 after edge N (registered FIFO write; no bypass).
- Redirect at edge N → byte_valid=0 after N. mem_req=1 with mem_addr=redirect_pc in the following cycle.
- Sustained rate is one byte per cycle when mem_ack is tied high and byte_ready=1.

## Configuration
- FETCH_PREFETCH_EN defined: the FIFO has DEPTH entries, and fetch runs ahead of the consumer.
- FETCH_PREFETCH_EN undefined: effective depth is 1 and DEPTH is ignored.
  - mem_req is asserted in RUN only when the buffer is empty.
  - All other rules are unchanged, so throughput is at most one byte per two cycles.

## Structure
- fetch_pkg holds the state enum fetch_state_t {IDLE, VEC_LO, VEC_HI, RUN}, the entry struct fetch_entry_t {data[7:0], pc[15:0]}, and the default vector constant.
- Sub-module fetch_fifo owns storage, read/write pointers and count.
  - Parameter DEPTH; synchronous flush; async reset.
- fetch_unit owns the FSM, PC and bus interface.

## Test plan
- Reset vector: mem[FFFC]=00, mem[FFFD]=80, mem_ack tied 1 → mem_addr sequence FFFC, FFFD, 8000, 8001. First byte_pc=8000, byte_data=mem[8000].
- Streaming: byte_ready=1, ack every cycle → one byte per cycle, byte_pc strictly incrementing from 8000, no gaps after the first.
- Backpressure: byte_ready=0 → exactly 4 pushes, then mem_req=0 and mem_addr=8004. A single-cycle byte_ready=1 → mem_req=1 in the next cycle, and a fifth byte arrives with byte_pc=8004.
- Redirect with simultaneous ack at 8002 → that byte is never presented. Next cycle byte_valid=0, then mem_addr=C000 and first byte_pc=C000.
- Wrap: redirect to FFFE → presented byte_pc sequence FFFE, FFFF, 0000, 0001.
- Async reset asserted mid-stream while mem_req=1 and count=3 → mem_req=0 and byte_valid=0 before the next edge. After release, the fetch sequence restarts at FFFC.
